// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int N_REQ      = 4;
    localparam int MAX_BURST  = 4;
    localparam int PTR_W      = $clog2(N_REQ);
    localparam int BURST_W    = 8;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: stateless round-robin selector; first set req bit at or above ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = fifo_arb_pkg::N_REQ,
    parameter int PW    = fifo_arb_pkg::PTR_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    idx
);

    always_comb begin
        logic          found;
        logic [PW:0]   sum;
        logic [PW-1:0] pos;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            pos = sum[PW-1:0];
            if (en && !found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers via a registered stage.
// Optional burst locking is compiled in with FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_arb_pkg::DATA_WIDTH,
    parameter int N_REQ      = fifo_arb_pkg::N_REQ,
    parameter int MAX_BURST  = fifo_arb_pkg::MAX_BURST
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            gnt,
    output logic                        fifo_wr_en,
    output logic [DATA_WIDTH-1:0]       fifo_wr_data,
    input  logic                        fifo_wr_ready
);

    localparam int PW = $clog2(N_REQ);

    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  stage_free;
    logic [PW-1:0]         win_idx, win_inc;
    logic [DATA_WIDTH-1:0] win_data;
    logic [DATA_WIDTH-1:0] masked [N_REQ];

    // A draining stage can accept a new word at the same edge, so there is no bubble.
    assign stage_free   = !out_vld_q || fifo_wr_ready;
    assign fifo_wr_en   = out_vld_q;
    assign fifo_wr_data = out_data_q;
    assign win_inc      = (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + 1'b1;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .en  (stage_free),
        .gnt (gnt),
        .idx (win_idx)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign masked[gi] = {DATA_WIDTH{gnt[gi]}} & req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_data = win_data | masked[i];
        end
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (|gnt) begin
            out_vld_d  = 1'b1;
            out_data_d = win_data;
        end else if (fifo_wr_ready) begin
            out_vld_d = 1'b0;
        end
    end

`ifdef FIFO_ARB_LOCK_EN
    logic [BURST_W-1:0] burst_q, burst_d, burst_inc;
    logic [PW-1:0]      ptr_inc;

    assign ptr_inc = (ptr_q == PW'(N_REQ-1)) ? '0 : ptr_q + 1'b1;

    // A grant to the locked producer extends its burst; any other winner starts a fresh one.
    always_comb begin
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        burst_inc = (win_idx == ptr_q && burst_q != '0) ? burst_q + 1'b1 : BURST_W'(1);
        if (|gnt) begin
            if (burst_inc >= BURST_W'(MAX_BURST)) begin
                ptr_d   = win_inc;
                burst_d = '0;
            end else begin
                ptr_d   = win_idx;
                burst_d = burst_inc;
            end
        end else if (stage_free && !req[ptr_q] && burst_q != '0) begin
            ptr_d   = ptr_inc;
            burst_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) begin
            ptr_d = win_inc;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            ptr_q      <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            ptr_q      <= ptr_d;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of one `fifo` instance between `N_REQ` independent producers. It selects one requesting producer per cycle and captures that producer's word into a registered output stage. It drives the FIFO's `wr_en`/`wr_data` from that stage and holds the word until the FIFO signals `wr_ready`. It sits between the producer blocks and the FIFO write side; the FIFO read side is untouched.

## Interface
- `DATA_WIDTH`, 8: width of each data word; must match the FIFO's `DATA_WIDTH`.
- `N_REQ`, 4: number of producers, 2..16.
- `MAX_BURST`, 4: maximum consecutive grants to one producer when the lock feature is compiled in, 1..255.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  `N_REQ`: bit i high means producer i offers a valid word this cycle.
- `req_data`  in  `N_REQ*DATA_WIDTH`: producer i's word in bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt`  out  `N_REQ`: one-hot. Bit i high means producer i's word is taken at this rising edge, and the producer advances. Combinational.
- `fifo_wr_en`  out  1: to the FIFO `wr_en`; high while the output stage holds a word.
- `fifo_wr_data`  out  `DATA_WIDTH`: to the FIFO `wr_data`; registered.
- `fifo_wr_ready`  in  1: from the FIFO `wr_ready`; high when the FIFO is not full.

## Operation
- Output stage:
  - Contents are `out_vld` and `out_data`.
  - `fifo_wr_en = out_vld` and `fifo_wr_data = out_data`.
  - The FIFO accepts the word at a rising edge when `fifo_wr_en && fifo_wr_ready`.
- Stage free condition: `stage_free = !out_vld || fifo_wr_ready`. The stage is free when it is empty or is being drained this cycle.
- Arbitration:
  - Arbitration happens only when `stage_free`.
  - The winner is the first set bit of `req`, searching from index `ptr` upward with wrap-around modulo `N_REQ`.
  - `gnt` is the one-hot of the winner. It is all-zero when `!stage_free` or when `req == 0`.
- On a rising edge:
  - If any `gnt` bit is set: `out_data` is loaded with the winner's word, `out_vld` is set to 1, and `ptr` becomes winner+1 (wraps to 0).
  - Otherwise, if `fifo_wr_ready` is high: `out_vld` is cleared to 0.
  - Otherwise: the stage holds its contents.
- Back-pressure:
  - While the FIFO is full, the stage holds its word with `fifo_wr_en` high.
  - `gnt` stays 0 and `req` lines are ignored.
  - `out_data` must not change while `out_vld && !fifo_wr_ready`.
- Fairness: each continuously requesting producer is granted at least once every `N_REQ` grants (without the lock feature).
- Reset values:
  - `out_vld = 0`, `out_data = 0`, `ptr = 0`, burst counter = 0.
  - Therefore `fifo_wr_en = 0`, `fifo_wr_data = 0`, `gnt = 0`.
- Reset mid-operation:
  - Any word held in the output stage is dropped.
  - Arbitration restarts from producer 0.

## Timing
- Latency:
  - Grant and capture happen in cycle N.
  - `fifo_wr_en` is high in cycle N+1.
  - With the FIFO ready, the FIFO write occurs at the end of cycle N+1.
- Throughput: one word per cycle when the FIFO is never full.
- Simultaneous drain and grant: when `out_vld && fifo_wr_ready` and some `req` bit is set, the old word is written and the new word is captured at the same edge. There is no bubble.
- `gnt` depends combinationally on `req`, `ptr`, `out_vld` and `fifo_wr_ready`. Producers must not make `req` depend on `gnt` in the same cycle.

## Configuration
- `FIFO_ARB_LOCK_EN` defined:
  - After producer i is granted, `ptr` stays at i while `req[i]` remains high, so i keeps winning.
  - This continues until `MAX_BURST` consecutive grants to i have occurred, tracked by an 8-bit burst counter.
  - On reaching `MAX_BURST`, `ptr` moves to i+1 and the counter clears.
  - A cycle with `stage_free` and `req[i]` low ends the burst: normal rotation resumes and the counter clears.
- `FIFO_ARB_LOCK_EN` not defined: pure round robin as above; no burst counter is instantiated.

## Structure
- Shared package `fifo_arb_pkg` holds:
  - the default constants `DATA_WIDTH`, `N_REQ`, `MAX_BURST`;
  - `PTR_W = $clog2(N_REQ)`.
- Sub-module `rr_pick` is combinational. It takes `req`, `ptr` and `en` and returns the one-hot `gnt` and the winner index. It has no state.
- All registers (`ptr`, output stage, burst counter) live in the top module.

## Test plan
- Reset asserted during a held word: `out_vld=1` with `fifo_wr_ready=0` and `reset` pulsed → `fifo_wr_en=0`, `gnt=0`, `ptr=0` on the next edge; after release, `req=4'b1000` is granted first.
- Full-rate round robin: `req=4'b1111`, data i = 8'h10+i, `fifo_wr_ready=1` → `gnt` sequence 0001, 0010, 0100, 1000, 0001 and FIFO receives 10, 11, 12, 13, 10 on consecutive cycles starting one cycle after the first grant.
- Sparse requests: `req=4'b0101` → `gnt` alternates 0001 and 0100; producers 1 and 3 are never granted.
- Back-pressure: hold `fifo_wr_ready=0` for 3 cycles with `out_data=8'hA5` → `fifo_wr_en=1`, `fifo_wr_data=8'hA5` stable and `gnt=0` for all 3 cycles. On ready, the next grant occurs in the same cycle as the A5 write.
- Integration with `fifo` (`DATA_WIDTH=8`, `FIFO_DEPTH=4`), no reads, `req=4'b0011` → exactly 4 words (alternating producers 0 and 1) are written. The 5th word is held until one `rd_en` cycle frees space, then it is written.
- With `FIFO_ARB_LOCK_EN` and `MAX_BURST=3`, `req=4'b0011` → `gnt` sequence 0001, 0001, 0001, 0010, 0010, 0010, 0001.
